// File: rtl/freq_scan_count.sv
// freq_scan_count
//   Multi-channel frequency counter core in the refclk domain. An internal
//   sequencer visits the NF channels round-robin. For each channel it lets
//   the pipeline settle for 3 cycles, then accumulates Gray-count deltas for
//   gate_len cycles with saturation, then stores the result.
//
// Ports
//   refclk      sole clock
//   rst         synchronous, active-high reset
//   gray_in     NF Gray counts, already in refclk; channel k at [k*gw +: gw]
//   gate_len    refclk cycles per gate; 0 parks the sequencer in IDLE
//   addr        readback address
//   frequency   stored result for addr (1-cycle latency)
//   freq_valid  entry at addr written since reset
//   freq_ovf    entry at addr saturated during its gate
//   cur_chan    channel currently being measured
//   sweep_done  one-cycle pulse after channel NF-1 is stored
module freq_scan_count #(
    parameter int NF = 8,
    parameter int NA = 3,
    parameter int gw = 4,
    parameter int rw = 24,
    parameter int uw = 28
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic [NF*gw-1:0] gray_in,
    input  logic [rw-1:0]    gate_len,
    input  logic [NA-1:0]    addr,
    output logic [uw-1:0]    frequency,
    output logic             freq_valid,
    output logic             freq_ovf,
    output logic [NA-1:0]    cur_chan,
    output logic             sweep_done
);

    typedef enum logic [1:0] {
        SETTLE,
        COUNT,
        STORE,
        IDLE
    } state_t;

    state_t        state, state_nxt;
    logic [rw-1:0] phase, phase_nxt;
    logic [rw-1:0] gate_r, gate_nxt;
    logic [NA-1:0] chan_nxt;
    logic [NA-1:0] chan_inc;

    // datapath
    logic [gw-1:0] g1, b2, b3, d3;
    logic [uw-1:0] accum;
    logic          ovf_acc;
    logic [uw:0]   sum;

    // result storage
    logic [uw-1:0] mem [NF];
    logic [NF-1:0] valid;
    logic [NF-1:0] ovf;

    function automatic logic [gw-1:0] g2b(input logic [gw-1:0] g);
        logic [gw-1:0] b;
        b[gw-1] = g[gw-1];
        for (int unsigned i = gw - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge refclk) begin
        if (rst) begin
            state    <= SETTLE;
            phase    <= '0;
            gate_r   <= '0;
            cur_chan <= '0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            gate_r   <= gate_nxt;
            cur_chan <= chan_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        gate_nxt  = gate_r;
        chan_nxt  = cur_chan;
        chan_inc  = (cur_chan == NA'(NF - 1)) ? '0 : cur_chan + 1'b1;
        case (state)
            SETTLE: begin
                if (phase == rw'(2)) begin
                    phase_nxt = '0;
                    if (gate_len == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = COUNT;
                        gate_nxt  = gate_len;
                    end
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            COUNT: begin
                if (phase == gate_r - 1'b1) begin
                    phase_nxt = '0;
                    state_nxt = STORE;
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            STORE: begin
                state_nxt = SETTLE;
                chan_nxt  = chan_inc;
            end
            IDLE: begin
                if (gate_len != '0) begin
                    state_nxt = SETTLE;
                    phase_nxt = '0;
                end
            end
            default: state_nxt = SETTLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: select -> gray-to-binary -> delta
    // The delta is taken combinationally at the stage-3 input (b2 - b3), so
    // that after the 3 settle cycles every accumulated delta comes from two
    // samples of the current channel, including the first gate after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge refclk) begin
        if (rst) begin
            g1 <= '0;
            b2 <= '0;
            b3 <= '0;
        end else begin
            g1 <= gray_in[int'(cur_chan)*gw +: gw];
            b2 <= g2b(g1);
            b3 <= b2;
        end
    end

    assign d3  = b2 - b3;
    assign sum = {1'b0, accum} + {{(uw + 1 - gw){1'b0}}, d3};

    always_ff @(posedge refclk) begin
        if (rst) begin
            accum   <= '0;
            ovf_acc <= 1'b0;
        end else if (state == COUNT) begin
            if (sum[uw]) begin
                accum   <= '1;
                ovf_acc <= 1'b1;
            end else begin
                accum <= sum[uw-1:0];
            end
        end else begin
            accum   <= '0;
            ovf_acc <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Result storage and readback
    // ------------------------------------------------------------------
    always_ff @(posedge refclk) begin
        if (!rst && state == STORE) begin
            mem[cur_chan] <= accum;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            valid      <= '0;
            ovf        <= '0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= (state == STORE) && (cur_chan == NA'(NF - 1));
            if (state == STORE) begin
                valid[cur_chan] <= 1'b1;
                ovf[cur_chan]   <= ovf_acc;
            end
        end
    end

    // Unwritten entries read as 0 so undefined RAM contents never escape.
    always_ff @(posedge refclk) begin
        if (rst) begin
            frequency  <= '0;
            freq_valid <= 1'b0;
            freq_ovf   <= 1'b0;
        end else if (int'(addr) < NF) begin
            frequency  <= valid[addr] ? mem[addr] : '0;
            freq_valid <= valid[addr];
            freq_ovf   <= ovf[addr];
        end else begin
            frequency  <= '0;
            freq_valid <= 1'b0;
            freq_ovf   <= 1'b0;
        end
    end

endmodule

// File: doc/freq_scan_count.md
Name: freq_scan_count

Overview:
- Next-generation multi-channel frequency counter core, running entirely in the refclk domain.
- Takes NF Gray-code counts that are already synchronized into refclk and scans them round-robin with an internal sequencer. No external clksel or ref_carry is needed.
- Per channel: programmable gate length, saturating accumulation with overflow flag, and a per-entry valid bit.
- Results sit in a small readback RAM read by the host register bank. A sweep-complete strobe is provided.

Parameters:
- NF, 8, number of channels.
- NA, 3, address width, ceil(log2(NF)).
- gw, 4, Gray code width per channel.
- rw, 24, gate-length width.
- uw, 28, result width.

Ports:
- refclk  input  1  sole clock.
- rst  input  1  synchronous, active-high reset.
- gray_in  input  NF*gw  per-channel Gray counts, already in refclk domain; channel k occupies bits [k*gw +: gw].
- gate_len  input  rw  refclk cycles per measurement gate; 0 disables scanning.
- addr  input  NA  readback address.
- frequency  output  uw  result for addr.
- freq_valid  output  1  entry at addr written since reset.
- freq_ovf  output  1  entry at addr saturated.
- cur_chan  output  NA  channel currently being measured.
- sweep_done  output  1  one-cycle pulse after the last channel is stored.

Behaviour:
- Clocking and reset: one clock, refclk. Reset is synchronous and active-high on rst. While rst is high:
  - FSM is forced to SETTLE with cur_chan=0 and the phase counter cleared.
  - accum, the pipeline registers, all valid bits, all ovf bits, sweep_done, frequency, freq_valid and freq_ovf are cleared to 0.
  - RAM data contents are don't-care.
- Datapath pipeline (every cycle):
  - Stage 1: g1 <= gray_in[cur_chan].
  - Stage 2: b2 <= gray-to-binary(g1).
  - Stage 3: b3 <= b2 and d3 <= b2 - b3, computed modulo 2^gw.
  - Input frequency must stay below (2^gw - 1) * f_refclk; faster inputs alias.
- FSM state SETTLE:
  - Lasts exactly 3 cycles, counted by the phase counter; accum is held at 0.
  - Flushes the previous channel out of the pipeline.
  - On the 3rd cycle: latch gate_len into gate_r and go to COUNT. If gate_len==0, go to IDLE instead.
- FSM state COUNT:
  - Lasts gate_r cycles; each cycle accum <= sat(accum + d3).
  - sat clamps at 2^uw - 1 and sets a sticky ovf_acc bit.
  - After gate_r cycles go to STORE.
- FSM state STORE (1 cycle):
  - Write mem[cur_chan] <= accum, set valid[cur_chan]=1, ovf[cur_chan]=ovf_acc.
  - Clear accum and ovf_acc.
  - cur_chan <= cur_chan+1, wrapping from NF-1 to 0 (NF need not be a power of 2).
  - Go to SETTLE.
  - If the stored channel was NF-1, sweep_done is high for exactly the following cycle.
- FSM state IDLE:
  - Entered when gate_len==0 at the end of SETTLE; accum is held at 0.
  - Leaves to SETTLE (phase counter cleared, cur_chan unchanged) on the first cycle gate_len != 0.
  - Existing results and valid bits are kept.
- gate_len changes: only sampled at the end of SETTLE. A change mid-COUNT has no effect on the gate in progress.
- Per-channel timing: gate_len+4 cycles per channel; a sweep takes NF*(gate_len+4) cycles.
- Readback:
  - frequency, freq_valid and freq_ovf are registered with 1-cycle latency from addr.
  - A read of the same address in the STORE cycle returns the old value; the new value is visible the next cycle.
  - addr >= NF returns 0/0/0.

Test Plan:
1. Count accuracy: NF=4, gw=4, uw=16, gate_len=100; Gray inputs advance 1, 2, 3, 0 counts/cycle on channels 0–3 -> after the first sweep_done, reads give 100, 200, 300, 0, all valid=1, ovf=0.
2. Sweep timing (setup as test 1) -> sweep_done first pulses 416 cycles after the first cycle with rst low; next pulse 416 cycles later; cur_chan sequence is 0, 1, 2, 3, 0.
3. Saturation: uw=8, channel 2 at 3 counts/cycle, gate_len=100 -> entry 2 reads 255 with ovf=1. Then gate_len=50 -> the next sweep reads 150 with ovf=0.
4. Disable/resume: gate_len=0 from reset -> FSM enters IDLE, no sweep_done, valid stays 0. Set gate_len=20 -> scan starts at channel 0 and channel 0 reads 20 × its rate.
5. Reset mid-operation: assert rst for 1 cycle during COUNT of channel 2 after a completed sweep -> all freq_valid read 0 next, cur_chan=0, and the next sweep reproduces test 1 values.
6. Edge cases: NF=5 (non-power-of-2) -> cur_chan wraps 4 to 0 and addr 5–7 reads 0/invalid. Gray counter wrapping modulo 2^gw every 16 counts -> no count lost. gate_len changed mid-COUNT -> current gate unaffected.
